// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: accepts a target RGB colour over a valid/ready handshake
// and fades the three 8-bit channel levels toward it by STEP once per fade
// tick. A tick comes from a free-running PRESCALE counter. When every channel
// has reached its target, o_done pulses for one cycle.
//
// Parameters
//   PRESCALE  i_clock cycles per fade tick (1..2^24)
//   STEP      per-tick channel change (1..255)
// Ports
//   i_clock, i_reset                 clock, synchronous active-high reset
//   i_valid / o_ready                command handshake; o_ready high only in IDLE
//   i_red, i_green, i_blue           target levels, captured on accept
//   o_red, o_green, o_blue           current levels, fed to the PWM stage
//   o_done                           one-cycle completion pulse
// Build option
//   RGB_FADE_GAMMA_EN  when defined, each output is the registered gamma curve
//                      (c*(c+1))>>8, and o_done is delayed one cycle to match.

// One colour channel: holds the target and current level and walks the
// current level toward the target on each step strobe.
module rgb_fade_lane #(
  parameter int STEP = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [7:0] i_tgt,
  output logic [7:0] o_lvl,
  output logic       o_at_tgt
);
  localparam logic [7:0] STEP_B = 8'(STEP);

  logic [7:0] cur_q, cur_d;
  logic [7:0] tgt_q, tgt_d;
  logic [7:0] diff;

  // The distance is compared against STEP before adding or subtracting it,
  // so the result always lies between the current level and the target and
  // can never wrap past 0 or 255.
  always_comb begin
    cur_d = cur_q;
    tgt_d = tgt_q;
    diff  = 8'd0;
    if (i_load) tgt_d = i_tgt;
    if (i_step) begin
      if (cur_q < tgt_q) begin
        diff  = tgt_q - cur_q;
        cur_d = (diff >= STEP_B) ? cur_q + STEP_B : tgt_q;
      end else if (cur_q > tgt_q) begin
        diff  = cur_q - tgt_q;
        cur_d = (diff >= STEP_B) ? cur_q - STEP_B : tgt_q;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cur_q <= 8'd0;
      tgt_q <= 8'd0;
    end else begin
      cur_q <= cur_d;
      tgt_q <= tgt_d;
    end
  end

  assign o_at_tgt = (cur_q == tgt_q);

`ifdef RGB_FADE_GAMMA_EN
  logic [15:0] sq;
  logic [7:0]  gam_q, gam_d;

  // c*(c+1) peaks at 255*256 = 65280, so 16 bits hold it exactly.
  always_comb begin
    sq    = {8'd0, cur_q} * ({8'd0, cur_q} + 16'd1);
    gam_d = 8'(sq >> 8);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) gam_q <= 8'd0;
    else         gam_q <= gam_d;
  end

  assign o_lvl = gam_q;
`else
  assign o_lvl = cur_q;
`endif
endmodule

module rgb_fade_sequencer #(
  parameter int PRESCALE = 120000,
  parameter int STEP     = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue,
  output logic       o_done
);
  localparam int NUM_LANES = 3;
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, FADE, DONE} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          tick, accept, step_en, all_eq;
  logic [NUM_LANES-1:0][7:0]     tgt_in, lvl;
  logic [NUM_LANES-1:0]          at_tgt;

  assign tgt_in = {i_blue, i_green, i_red};

  // Free-running tick counter, independent of command accept. With
  // PRESCALE=1 CNT_MAX is 0 and every cycle is a tick.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  assign o_ready = (state_q == IDLE);
  assign accept  = o_ready & i_valid;
  assign step_en = (state_q == FADE) & tick;
  assign all_eq  = &at_tgt;

  // Completion is checked every cycle in FADE, so a command whose targets
  // already match the current levels finishes one edge after accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = FADE;
      FADE:    if (all_eq)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rgb_fade_lane #(.STEP(STEP)) u_lane (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_load   (accept),
      .i_step   (step_en),
      .i_tgt    (tgt_in[g]),
      .o_lvl    (lvl[g]),
      .o_at_tgt (at_tgt[g])
    );
  end

  assign o_red   = lvl[0];
  assign o_green = lvl[1];
  assign o_blue  = lvl[2];

`ifdef RGB_FADE_GAMMA_EN
  // The gamma register delays the levels by one cycle; delay done to match.
  logic done_q, done_d;
  assign done_d = (state_q == DONE);
  always_ff @(posedge i_clock) begin
    if (i_reset) done_q <= 1'b0;
    else         done_q <= done_d;
  end
  assign o_done = done_q;
`else
  assign o_done = (state_q == DONE);
`endif
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
module tb_rgb_fade_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v1, rdy1, done1;
  logic [7:0] r1, g1, b1, or1, og1, ob1;
  logic       v2, rdy2, done2;
  logic [7:0] r2, g2, b2, or2, og2, ob2;

  int passed = 0;
  int total  = 0;
  int n, dones, nchg, va, vb, vc, gab, gbc;
  bit got;

  rgb_fade_sequencer #(.PRESCALE(4), .STEP(1)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(v1), .o_ready(rdy1),
    .i_red(r1), .i_green(g1), .i_blue(b1),
    .o_red(or1), .o_green(og1), .o_blue(ob1), .o_done(done1)
  );

  rgb_fade_sequencer #(.PRESCALE(4), .STEP(100)) dut100 (
    .i_clock(clk), .i_reset(rst), .i_valid(v2), .o_ready(rdy2),
    .i_red(r2), .i_green(g2), .i_blue(b2),
    .o_red(or2), .o_green(og2), .o_blue(ob2), .o_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic adv(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Follow the STEP=100 instance until o_done, recording the first three
  // distinct o_red values and the cycle gaps between them.
  task automatic watch2(output int nc, output int a, output int b, output int c,
                        output int g_ab, output int g_bc, output bit seen);
    int prev, k, ca, cb, cc;
    prev = int'(or2); nc = 0; k = 0; seen = 0;
    a = -1; b = -1; c = -1; ca = 0; cb = 0; cc = 0;
    while (k < 80 && !seen) begin
      adv(1);
      k++;
      if (int'(or2) != prev) begin
        case (nc)
          0: begin a = int'(or2); ca = k; end
          1: begin b = int'(or2); cb = k; end
          2: begin c = int'(or2); cc = k; end
          default: ;
        endcase
        nc++;
        prev = int'(or2);
      end
      if (done2) seen = 1;
    end
    g_ab = cb - ca;
    g_bc = cc - cb;
  endtask

  initial begin
    rst = 1'b1;
    v1 = 0; r1 = 0; g1 = 0; b1 = 0;
    v2 = 0; r2 = 0; g2 = 0; b2 = 0;
    adv(3);
    rst = 1'b0;
    // Tick counter is 0 here; after the k-th further edge it reads k mod 4.
    check("rst_red",   or1,   0);
    check("rst_green", og1,   0);
    check("rst_blue",  ob1,   0);
    check("rst_ready", rdy1,  1);
    check("rst_done",  done1, 0);
    check("rst_ready2", rdy2, 1);

`ifndef RGB_FADE_GAMMA_EN
    // Fade red 0 -> 3, one step per tick, ticks 4 cycles apart.
    v1 = 1; r1 = 8'd3;
    adv(1);                           // E1 accept
    check("a_ready_low", rdy1, 0);
    check("a_red_e1",    or1,  0);
    v1 = 0; r1 = 8'd0;
    adv(2); check("a_red_e3", or1, 0);
    adv(1); check("a_red_e4", or1, 1);
    adv(3); check("a_red_e7", or1, 1);
    adv(1); check("a_red_e8", or1, 2);
    adv(4); check("a_red_e12",   or1,   3);
            check("a_done_e12",  done1, 0);
            check("a_green_e12", og1,   0);
    adv(1); check("a_done_e13",  done1, 1);
            check("a_ready_e13", rdy1,  0);
    adv(1); check("a_done_e14",  done1, 0);
            check("a_ready_e14", rdy1,  1);
            check("a_red_e14",   or1,   3);

    // Second command held with valid high during a fade must wait for ready.
    v1 = 1; r1 = 8'd5;
    adv(1);                           // E15 accept target 5
    check("b_ready_low", rdy1, 0);
    r1 = 8'd50; g1 = 8'd50; b1 = 8'd50;
    adv(1); check("b_red_e16", or1, 4);
    adv(4); check("b_red_e20", or1, 5);
            check("b_green_e20", og1, 0);
    adv(1); check("b_done_e21", done1, 1);
            check("b_red_e21",  or1,   5);
    adv(1); check("b_ready_e22", rdy1, 1);
            check("b_done_e22",  done1, 0);
    adv(1); check("b_accept_e23", rdy1, 0);
    v1 = 0;
    n = 0; got = 0; dones = 0;
    while (n < 400 && !got) begin
      adv(1); n++;
      if (done1) begin got = 1; dones++; end
    end
    check("b_done_seen", got, 1);
    check("b_red50",   or1, 50);
    check("b_green50", og1, 50);
    check("b_blue50",  ob1, 50);
    repeat (6) begin
      adv(1);
      if (done1) dones++;
    end
    check("b_done_once", dones, 1);
    check("b_ready_end", rdy1, 1);

    // Reset mid-fade: no done pulse, outputs cleared.
    rst = 1; adv(1); rst = 0;
    check("c_rst_red", or1, 0);
    v1 = 1; r1 = 8'd200; g1 = 0; b1 = 0;
    adv(1);
    v1 = 0;
    n = 0; got = 0;
    while (n < 40 && !got) begin
      adv(1); n++;
      if (or1 == 8'd2) got = 1;
    end
    check("c_reached2", got, 1);
    rst = 1; adv(1); rst = 0;
    check("c_red0",   or1,   0);
    check("c_ready1", rdy1,  1);
    check("c_done0",  done1, 0);
    dones = 0;
    repeat (20) begin
      adv(1);
      if (done1) dones++;
    end
    check("c_no_done", dones, 0);
    check("c_red_hold", or1, 0);

    // Target equal to current level: done one edge after the accept edge.
    v1 = 1; r1 = 0; g1 = 0; b1 = 0;
    adv(1);
    v1 = 0;
    check("d_ready_low", rdy1,  0);
    check("d_done_e0",   done1, 0);
    adv(1);
    check("d_done_e1", done1, 1);
    check("d_red",     or1,   0);
    check("d_green",   og1,   0);
    check("d_blue",    ob1,   0);
    adv(1);
    check("d_done_e2",  done1, 0);
    check("d_ready_e2", rdy1,  1);

    // STEP=100: saturating approach up to 255, then down to 10.
    v2 = 1; r2 = 8'd255;
    adv(1);
    v2 = 0;
    check("e_ready_low", rdy2, 0);
    watch2(nchg, va, vb, vc, gab, gbc, got);
    check("e_up_done", got,  1);
    check("e_up_nchg", nchg, 3);
    check("e_up_v0",   va,   100);
    check("e_up_v1",   vb,   200);
    check("e_up_v2",   vc,   255);
    check("e_up_gap0", gab,  4);
    check("e_up_gap1", gbc,  4);
    adv(1);
    check("e_idle", rdy2, 1);
    v2 = 1; r2 = 8'd10;
    adv(1);
    v2 = 0;
    watch2(nchg, va, vb, vc, gab, gbc, got);
    check("e_dn_done", got,  1);
    check("e_dn_nchg", nchg, 3);
    check("e_dn_v0",   va,   155);
    check("e_dn_v1",   vb,   55);
    check("e_dn_v2",   vc,   10);
    check("e_dn_gap0", gab,  4);
`else
    // Gamma path: output seen at the done pulse is the final gamma value.
    v2 = 1; r2 = 8'd255;
    adv(1);
    v2 = 0;
    n = 0; got = 0;
    while (n < 80 && !got) begin
      adv(1); n++;
      if (done2) got = 1;
    end
    check("g_done255", got, 1);
    check("g_red255",  or2, 255);
    v1 = 1; r1 = 8'd128;
    adv(1);
    v1 = 0;
    n = 0; got = 0;
    while (n < 700 && !got) begin
      adv(1); n++;
      if (done1) got = 1;
    end
    check("g_done128", got, 1);
    check("g_red128",  or1, 64);
    check("g_green0",  og1, 0);
    adv(1);
    check("g_done_gone", done1, 0);
    check("g_ready",     rdy1,  1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
